// File: rtl/iob_noc_bridge_pkg.sv
// Shared header field positions, message constants and inbound FSM encoding
// for the IOB NoC bridge.
package iob_noc_bridge_pkg;

  localparam int MSG_DST_X_HI  = 49;
  localparam int MSG_DST_X_LO  = 42;
  localparam int MSG_DST_Y_HI  = 41;
  localparam int MSG_DST_Y_LO  = 34;
  localparam int MSG_FBITS_HI  = 33;
  localparam int MSG_FBITS_LO  = 30;
  localparam int MSG_LENGTH_HI = 29;
  localparam int MSG_LENGTH_LO = 22;
  localparam int MSG_TYPE_HI   = 21;
  localparam int MSG_TYPE_LO   = 14;

  localparam logic [3:0] NOC_FBITS_L1       = 4'b0000;
  localparam logic [7:0] MSG_TYPE_INTERRUPT = 8'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2,
    ST_DONE = 2'd3
  } in_state_e;

  // Header flit of a single-payload interrupt packet; unnamed fields stay zero.
  function automatic logic [63:0] int_hdr(input logic [7:0] dst_x, input logic [7:0] dst_y);
    logic [63:0] h;
    h = '0;
    h[MSG_DST_X_HI:MSG_DST_X_LO]   = dst_x;
    h[MSG_DST_Y_HI:MSG_DST_Y_LO]   = dst_y;
    h[MSG_FBITS_HI:MSG_FBITS_LO]   = NOC_FBITS_L1;
    h[MSG_LENGTH_HI:MSG_LENGTH_LO] = 8'd1;
    h[MSG_TYPE_HI:MSG_TYPE_LO]     = MSG_TYPE_INTERRUPT;
    return h;
  endfunction

endpackage

// File: rtl/iob_pkt_fifo.sv
// Synchronous FIFO with extended pointers; exposes the head entry and the one
// behind it so a consumer can chain entries without a bubble.
module iob_pkt_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] head_nxt_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         multi_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_q, rd_q, count;
  logic [AW-1:0] rd_idx, rd_nxt_idx;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign count      = wr_q - rd_q;
  assign empty_o    = (wr_q == rd_q);
  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign multi_o    = (count > (AW+1)'(1));
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign rd_idx     = rd_q[AW-1:0];
  assign rd_nxt_idx = rd_idx + AW'(1);
  assign head_o     = mem_q[rd_idx];
  assign head_nxt_o = mem_q[rd_nxt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage carries no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/iob_noc_bridge.sv
// Chip-bridge NoC endpoint: assembles inbound packets for the IOB model and
// turns interrupt requests into 2-flit NoC packets through a packet FIFO.
module iob_noc_bridge
  import iob_noc_bridge_pkg::*;
#(
  parameter int DW        = 64,
  parameter int IN_FLITS  = 4,
  parameter int OUT_DEPTH = 8,
  parameter int GRID_X    = 8,
  parameter int GRID_Y    = 8,
  parameter int TID_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           noc_in_val_i,
  output logic                           noc_in_rdy_o,
  input  logic [DW-1:0]                  noc_in_data_i,
  output logic                           req_val_o,
  input  logic                           req_rdy_i,
  output logic [$clog2(IN_FLITS+1)-1:0]  req_len_o,
  output logic [IN_FLITS*DW-1:0]         req_data_o,
  input  logic                           int_val_i,
  output logic                           int_rdy_o,
  input  logic [TID_W-1:0]               int_tileid_i,
  input  logic [63:0]                    int_data_i,
  output logic                           noc_out_val_o,
  input  logic                           noc_out_rdy_i,
  output logic [DW-1:0]                  noc_out_data_o,
  output logic                           err_bad_len_o,
  output logic                           err_bad_tile_o
);

  localparam int              LW      = $clog2(IN_FLITS+1);
  localparam logic [8:0]      MAX_LEN = 9'(IN_FLITS);
  localparam logic [TID_W-1:0] N_TILES = TID_W'(GRID_X*GRID_Y);
  localparam logic [TID_W-1:0] GX      = TID_W'(GRID_X);

  // ---------------- inbound assembly ----------------
  in_state_e      state_q;
  logic           rdy_q, req_val_q, err_len_q;
  logic [LW-1:0]  len_q, cnt_q;
  logic [7:0]     drop_q;
  logic           in_fire, req_fire, hdr_bad;
  logic [7:0]     hdr_plen;
  logic [8:0]     hdr_len;

  assign in_fire  = noc_in_val_i & rdy_q;
  assign req_fire = req_val_q & req_rdy_i;
  assign hdr_plen = noc_in_data_i[MSG_LENGTH_HI:MSG_LENGTH_LO];
  assign hdr_len  = {1'b0, hdr_plen} + 9'd1;
  assign hdr_bad  = (hdr_len > MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      req_val_q <= 1'b0;
      err_len_q <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      drop_q    <= '0;
    end else begin
      err_len_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (in_fire) begin
            if (hdr_bad) begin
              state_q   <= ST_DROP;
              drop_q    <= hdr_plen;
              err_len_q <= 1'b1;
            end else if (hdr_plen == 8'd0) begin
              state_q   <= ST_DONE;
              rdy_q     <= 1'b0;
              req_val_q <= 1'b1;
              len_q     <= LW'(hdr_len);
            end else begin
              state_q <= ST_BODY;
              cnt_q   <= LW'(1);
              len_q   <= LW'(hdr_len);
            end
          end
        end
        ST_BODY: begin
          if (in_fire) begin
            if (cnt_q == len_q - LW'(1)) begin
              state_q   <= ST_DONE;
              rdy_q     <= 1'b0;
              req_val_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + LW'(1);
            end
          end
        end
        ST_DROP: begin
          if (in_fire) begin
            drop_q <= drop_q - 8'd1;
            if (drop_q == 8'd1) state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (req_fire) begin
            state_q   <= ST_IDLE;
            rdy_q     <= 1'b1;
            req_val_q <= 1'b0;
            len_q     <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Slot 0 holds the header; slots are wiped on handoff so unused ones read zero.
  for (genvar gi = 0; gi < IN_FLITS; gi++) begin : g_slot
    logic          we;
    logic [DW-1:0] slot_q;

    if (gi == 0) begin : g_hdr
      assign we = in_fire & (state_q == ST_IDLE) & ~hdr_bad;
    end else begin : g_pay
      assign we = in_fire & (state_q == ST_BODY) & (cnt_q == LW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        slot_q <= '0;
      else if (req_fire) slot_q <= '0;
      else if (we)       slot_q <= noc_in_data_i;
    end

    assign req_data_o[(IN_FLITS-gi)*DW-1 -: DW] = slot_q;
  end

  assign noc_in_rdy_o  = rdy_q;
  assign req_val_o     = req_val_q;
  assign req_len_o     = len_q;
  assign err_bad_len_o = err_len_q;

  // ---------------- outbound interrupts ----------------
  logic            run_q, err_tile_q;
  logic            int_fire, tile_ok, fifo_push, fifo_pop;
  logic            fifo_empty, fifo_full, fifo_multi;
  logic [7:0]      dst_x, dst_y;
  logic [DW-1:0]   flit1, flit2;
  logic [2*DW-1:0] fifo_head, fifo_head_nxt;
  logic [2*DW-1:0] entry_q;
  logic            out_val_q, phase_q, out_fire;
  logic            unused_bits;

  assign int_rdy_o   = run_q & ~fifo_full;
  assign int_fire    = int_val_i & int_rdy_o;
  assign tile_ok     = (int_tileid_i < N_TILES);
  assign fifo_push   = int_fire & tile_ok;
  assign dst_x       = 8'(int_tileid_i % GX);
  assign dst_y       = 8'(int_tileid_i / GX);
  assign unused_bits = ^int_data_i[15:9];

  always_comb begin
    flit1        = '0;
    flit1[63:0]  = int_hdr(dst_x, dst_y);
    flit2        = '0;
    flit2[63:0]  = {int_data_i[63:16], 7'b0, int_data_i[8:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      err_tile_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      err_tile_q <= int_fire & ~tile_ok;
    end
  end

  iob_pkt_fifo #(
    .W     (2*DW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i ({flit1, flit2}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .head_nxt_o  (fifo_head_nxt),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .multi_o     (fifo_multi)
  );

  // The head entry stays in the FIFO until its second flit is taken.
  assign out_fire = out_val_q & noc_out_rdy_i;
  assign fifo_pop = out_fire & phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val_q <= 1'b0;
      phase_q   <= 1'b0;
      entry_q   <= '0;
    end else if (!out_val_q) begin
      if (!fifo_empty) begin
        out_val_q <= 1'b1;
        phase_q   <= 1'b0;
        entry_q   <= fifo_head;
      end
    end else if (out_fire) begin
      if (!phase_q) begin
        phase_q <= 1'b1;
      end else begin
        phase_q <= 1'b0;
        if (fifo_multi) entry_q <= fifo_head_nxt;
        else            out_val_q <= 1'b0;
      end
    end
  end

  assign noc_out_val_o  = out_val_q;
  assign noc_out_data_o = phase_q ? entry_q[DW-1:0] : entry_q[2*DW-1:DW];
  assign err_bad_tile_o = err_tile_q;

endmodule

// File: tb/tb_iob_noc_bridge.sv
// Directed bench for iob_noc_bridge: table-driven inbound/outbound vectors plus
// hand-written backpressure, FIFO-full and mid-packet reset sequences.
module tb_iob_noc_bridge;

  localparam int DW = 64, IN_FLITS = 4, OUT_DEPTH = 8, GX = 8, GY = 8, TID_W = 32, LW = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   noc_in_val = 1'b0, noc_in_rdy;
  logic [DW-1:0]          noc_in_data = '0;
  logic                   req_val, req_rdy = 1'b1;
  logic [LW-1:0]          req_len;
  logic [IN_FLITS*DW-1:0] req_data;
  logic                   int_val = 1'b0, int_rdy;
  logic [TID_W-1:0]       int_tileid = '0;
  logic [63:0]            int_data = '0;
  logic                   noc_out_val, noc_out_rdy = 1'b1;
  logic [DW-1:0]          noc_out_data;
  logic                   err_bad_len, err_bad_tile;

  always #5 clk = ~clk;

  iob_noc_bridge #(
    .DW(DW), .IN_FLITS(IN_FLITS), .OUT_DEPTH(OUT_DEPTH),
    .GRID_X(GX), .GRID_Y(GY), .TID_W(TID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .noc_in_val_i(noc_in_val), .noc_in_rdy_o(noc_in_rdy), .noc_in_data_i(noc_in_data),
    .req_val_o(req_val), .req_rdy_i(req_rdy), .req_len_o(req_len), .req_data_o(req_data),
    .int_val_i(int_val), .int_rdy_o(int_rdy), .int_tileid_i(int_tileid), .int_data_i(int_data),
    .noc_out_val_o(noc_out_val), .noc_out_rdy_i(noc_out_rdy), .noc_out_data_o(noc_out_data),
    .err_bad_len_o(err_bad_len), .err_bad_tile_o(err_bad_tile)
  );

  int n_cmp = 0, n_bad = 0;
  int n_elen = 0, n_etile = 0, n_req = 0;

  always @(negedge clk) begin
    if (err_bad_len)       n_elen++;
    if (err_bad_tile)      n_etile++;
    if (req_val && req_rdy) n_req++;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [63:0] d);
    int g = 0;
    noc_in_val  = 1'b1;
    noc_in_data = d;
    while (!noc_in_rdy && g < 40) begin
      tick();
      g++;
    end
    if (!noc_in_rdy) timeout("noc_in_rdy");
    tick();
    noc_in_val = 1'b0;
  endtask

  task automatic offer_int(input logic [31:0] tid, input logic [63:0] d, output bit ok);
    int g = 0;
    int_val    = 1'b1;
    int_tileid = tid;
    int_data   = d;
    while (!int_rdy && g < 10) begin
      tick();
      g++;
    end
    ok = int_rdy;
    if (ok) tick();
    int_val = 1'b0;
  endtask

  task automatic get_flit(output logic [63:0] d, output bit ok);
    int g = 0;
    while (!noc_out_val && g < 20) begin
      tick();
      g++;
    end
    ok = noc_out_val;
    d  = noc_out_data;
    if (ok) tick();
  endtask

  function automatic logic [63:0] mk_hdr(input logic [7:0] plen, input logic [63:0] tag);
    return (tag & ~(64'hFF << 22)) | (64'(plen) << 22);
  endfunction

  function automatic logic [63:0] pf(input logic [63:0] tag, input int k);
    return tag ^ (64'(k) * 64'h0101_0101);
  endfunction

  function automatic logic [63:0] exp_f1(input logic [7:0] x, input logic [7:0] y);
    return (64'(x) << 42) | (64'(y) << 34) | (64'd1 << 22) | (64'd32 << 14);
  endfunction

  function automatic logic [63:0] exp_f2(input logic [63:0] d);
    return {d[63:16], 7'b0, d[8:0]};
  endfunction

  typedef struct {
    logic [7:0]  plen;
    logic [63:0] tag;
    int          exp_len;
    bit          exp_err;
  } in_vec_t;

  typedef struct {
    logic [31:0] tid;
    logic [63:0] d;
    logic [7:0]  ex;
    logic [7:0]  ey;
    bit          bad;
  } out_vec_t;

  in_vec_t  iv [7];
  out_vec_t ov [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  h, f;
    logic [255:0] expd, held;
    bit           ok;
    int           e0, r0, acc;

    iv[0] = '{8'd1, 64'hA1A1_0000_1234_5678, 2, 1'b0};
    iv[1] = '{8'd0, 64'hB2B2_0000_0000_00B2, 1, 1'b0};
    iv[2] = '{8'd3, 64'hC3C3_0000_0F0F_0F0F, 4, 1'b0};
    iv[3] = '{8'd5, 64'hD4D4_0000_0000_00D4, 0, 1'b1};
    iv[4] = '{8'd2, 64'hE5E5_0000_5555_AAAA, 3, 1'b0};
    iv[5] = '{8'd4, 64'hF6F6_0000_0000_00F6, 0, 1'b1};
    iv[6] = '{8'd1, 64'h1717_0000_7777_0001, 2, 1'b0};

    ov[0] = '{32'd19,         64'hDEAD_BEEF_CAFE_F1FF, 8'd3, 8'd2, 1'b0};
    ov[1] = '{32'd0,          64'h0123_4567_89AB_CDEF, 8'd0, 8'd0, 1'b0};
    ov[2] = '{32'd63,         64'hFFFF_FFFF_FFFF_FFFF, 8'd7, 8'd7, 1'b0};
    ov[3] = '{32'd8,          64'h1111_2222_3333_4444, 8'd0, 8'd1, 1'b0};
    ov[4] = '{32'd64,         64'h5555_6666_7777_8888, 8'd0, 8'd0, 1'b1};
    ov[5] = '{32'hFFFF_FFFF,  64'h9999_AAAA_BBBB_CCCC, 8'd0, 8'd0, 1'b1};
    ov[6] = '{32'd42,         64'h0F0F_F0F0_0F0F_FE00, 8'd2, 8'd5, 1'b0};

    // Outputs during reset
    #12;
    chk("rst noc_in_rdy", noc_in_rdy, 0);
    chk("rst int_rdy", int_rdy, 0);
    chk("rst req_val/len/data", {req_val, req_len, req_data[63:0]}, 0);
    chk("rst out val/data/errs", {noc_out_val, noc_out_data, err_bad_len, err_bad_tile}, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post-rst noc_in_rdy", noc_in_rdy, 1);
    chk("post-rst int_rdy", int_rdy, 1);

    // Inbound table
    for (int v = 0; v < 7; v++) begin
      e0 = n_elen;
      r0 = n_req;
      h  = mk_hdr(iv[v].plen, iv[v].tag);
      send_flit(h);
      for (int k = 1; k <= int'(iv[v].plen); k++) send_flit(pf(iv[v].tag, k));
      if (iv[v].exp_err) begin
        tick();
        tick();
        chk($sformatf("in%0d err_bad_len pulses", v), n_elen - e0, 1);
        chk($sformatf("in%0d no req", v), n_req - r0, 0);
      end else begin
        expd = '0;
        expd[255 -: 64] = h;
        for (int k = 1; k < iv[v].exp_len; k++) expd[(IN_FLITS-k)*64-1 -: 64] = pf(iv[v].tag, k);
        chk($sformatf("in%0d req_val latency", v), req_val, 1);
        chk($sformatf("in%0d req_len", v), req_len, iv[v].exp_len);
        chk($sformatf("in%0d req_data", v), req_data, expd);
        tick();
        chk($sformatf("in%0d req count", v), n_req - r0, 1);
        chk($sformatf("in%0d no err", v), n_elen - e0, 0);
      end
    end

    // req_rdy backpressure holds the packet and blocks the inbound side
    req_rdy = 1'b0;
    h = mk_hdr(8'd2, 64'h5A5A_0000_1111_2222);
    send_flit(h);
    send_flit(pf(64'h5A5A_0000_1111_2222, 1));
    send_flit(pf(64'h5A5A_0000_1111_2222, 2));
    held = {h, pf(64'h5A5A_0000_1111_2222, 1), pf(64'h5A5A_0000_1111_2222, 2), 64'h0};
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d req_val", c), req_val, 1);
      chk($sformatf("stall%0d noc_in_rdy", c), noc_in_rdy, 0);
      chk($sformatf("stall%0d req_data", c), req_data, held);
      tick();
    end
    req_rdy = 1'b1;
    tick();
    chk("stall release req_val", req_val, 0);
    chk("stall release slots cleared", req_data, 0);
    chk("stall release noc_in_rdy", noc_in_rdy, 1);

    // Outbound table
    noc_out_rdy = 1'b1;
    for (int v = 0; v < 7; v++) begin
      e0 = n_etile;
      offer_int(ov[v].tid, ov[v].d, ok);
      if (!ok) timeout($sformatf("out%0d int_rdy", v));
      if (ov[v].bad) begin
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("out%0d noc_out_val idle", v), noc_out_val, 0);
          tick();
        end
        chk($sformatf("out%0d err_bad_tile pulses", v), n_etile - e0, 1);
      end else begin
        get_flit(f, ok);
        if (!ok) timeout($sformatf("out%0d flit1", v));
        chk($sformatf("out%0d flit1", v), f, exp_f1(ov[v].ex, ov[v].ey));
        get_flit(f, ok);
        if (!ok) timeout($sformatf("out%0d flit2", v));
        chk($sformatf("out%0d flit2", v), f, exp_f2(ov[v].d));
        chk($sformatf("out%0d no err", v), n_etile - e0, 0);
      end
    end
    tick();
    chk("outbound drained", noc_out_val, 0);

    // FIFO fill under noc_out_rdy=0, then drain in order
    noc_out_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      offer_int(32'(i), 64'hABCD_0000_0000_FFFF | (64'(i) << 16), ok);
      if (ok) acc++;
    end
    chk("full accepted count", acc, 8);
    chk("full int_rdy", int_rdy, 0);
    chk("stalled out val", noc_out_val, 1);
    chk("stalled out data", noc_out_data, exp_f1(8'd0, 8'd0));
    tick();
    tick();
    chk("stalled out data held", noc_out_data, exp_f1(8'd0, 8'd0));
    noc_out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      get_flit(f, ok);
      if (!ok) timeout($sformatf("drain%0d flit1", i));
      chk($sformatf("drain%0d flit1", i), f, exp_f1(8'(i), 8'd0));
      get_flit(f, ok);
      if (!ok) timeout($sformatf("drain%0d flit2", i));
      chk($sformatf("drain%0d flit2", i), f, exp_f2(64'hABCD_0000_0000_FFFF | (64'(i) << 16)));
    end
    tick();
    chk("drain empty", noc_out_val, 0);
    chk("drain int_rdy", int_rdy, 1);

    // Asynchronous reset mid-packet with the outbound FIFO occupied
    noc_out_rdy = 1'b0;
    offer_int(32'd5, 64'h1234_5678_9ABC_DEF0, ok);
    if (!ok) timeout("arst int_rdy");
    send_flit(mk_hdr(8'd3, 64'h3C3C_0000_0000_0003));
    send_flit(pf(64'h3C3C_0000_0000_0003, 1));
    tick();
    chk("arst pre out val", noc_out_val, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst noc_in_rdy", noc_in_rdy, 0);
    chk("arst int_rdy", int_rdy, 0);
    chk("arst req", {req_val, req_len}, 0);
    chk("arst req_data", req_data, 0);
    chk("arst out", {noc_out_val, noc_out_data}, 0);
    chk("arst errs", {err_bad_len, err_bad_tile}, 0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst fifo flushed", noc_out_val, 0);
    noc_out_rdy = 1'b1;
    r0 = n_req;
    h = mk_hdr(8'd1, 64'h6E6E_0000_ABCD_0006);
    send_flit(h);
    send_flit(pf(64'h6E6E_0000_ABCD_0006, 1));
    chk("arst fresh req_val", req_val, 1);
    chk("arst fresh req_len", req_len, 2);
    chk("arst fresh req_data", req_data, {h, pf(64'h6E6E_0000_ABCD_0006, 1), 128'h0});
    tick();
    chk("arst fresh req count", n_req - r0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
